// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level RV32I requests into 32-bit words and writes them to consecutive IMEM words.
// Latency: accept at edge N -> imem_we/imem_addr/imem_din valid during cycle N+1; count follows at edge N+1.
// Backpressure: in_ready is low outside RUN, during start, and once the DEPTH word budget (incl. pending write) is used.
//
// Ports:
//   clk, rst_n            sole clock; synchronous active-low reset
//   start                 rewind the writer to BASE_ADDR and enter RUN (restarts from any state)
//   in_valid/in_ready     request handshake; in_ready never depends on in_valid
//   in_fmt..in_imm        instruction fields (fmt 0 R,1 I,2 S,3 B,4 U,5 J; 6-7 illegal)
//   in_last               final request of the program
//   imem_we/addr/din      one-cycle IMEM write strobe, word address and encoded word
//   count                 words written since start
//   done, err             DONE state flag; sticky illegal-request-dropped flag
//
// Optional build macro: INSTR_ENCODER_RANGE_CHECK_EN -- immediates that do not fit their
// format are dropped like illegal formats instead of being silently truncated.

module instr_encoder #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_din,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q;
   logic [31:0]         enc_word;
   logic                fmt_ok;
   logic                range_ok;
   logic                legal;
   logic                accept;
   logic [ADDR_W+1:0]   words_used;

   // Words committed so far, including a write registered last cycle that has not yet hit count.
   assign words_used = {1'b0, count} + {{(ADDR_W+1){1'b0}}, imem_we};
   assign accept     = in_valid && in_ready;
   assign fmt_ok     = (in_fmt <= 3'd5);
   assign legal      = fmt_ok && range_ok;

   always_comb begin
      enc_word = '0;
      case (in_fmt)
         3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
         3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
         3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         default: enc_word = '0;
      endcase
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   // Sign-extension checks: every bit above the encodable field must equal the field's sign bit.
   always_comb begin
      range_ok = 1'b1;
      case (in_fmt)
         3'd1, 3'd2: range_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
         3'd3:       range_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
         3'd4:       range_ok = (in_imm[11:0] == 12'd0);
         3'd5:       range_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
         default:    range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (start) begin
               state_d = RUN;
            end else begin
               in_ready = (words_used < DEPTH_W);
               // Leave RUN on the last request, or on the write that exhausts the word budget.
               if (accept && (in_last || (legal && (words_used + 1'b1 == DEPTH_W))))
                  state_d = DONE;
            end
         end
         DONE: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q     <= BASE;
         imem_we   <= 1'b0;
         imem_addr <= BASE;
         imem_din  <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         // A write registered last cycle is still presented this cycle even across a restart.
         imem_we <= accept && legal;
         if (accept && legal) begin
            imem_addr <= ptr_q;
            imem_din  <= enc_word;
            ptr_q     <= ptr_q + 1'b1;
         end
         if (start) begin
            ptr_q <= BASE;
            count <= '0;
            err   <= 1'b0;
         end else begin
            count <= count + {{ADDR_W{1'b0}}, imem_we};
            if (accept && !legal) err <= 1'b1;
         end
      end
   end

   assign done = (state_q == DONE);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   localparam int AW_A = 4, BASE_A = 13, DEPTH_A = 16;
   localparam int AW_B = 3, BASE_B = 6,  DEPTH_B = 4;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, in_last;
   logic [2:0]  in_fmt, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;

   logic              in_ready_a, imem_we_a, done_a, err_a;
   logic [AW_A-1:0]   imem_addr_a;
   logic [31:0]       imem_din_a;
   logic [AW_A:0]     count_a;
   logic              in_ready_b, imem_we_b, done_b, err_b;
   logic [AW_B-1:0]   imem_addr_b;
   logic [31:0]       imem_din_b;
   logic [AW_B:0]     count_b;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW_A), .BASE_ADDR(BASE_A), .DEPTH(DEPTH_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_din(imem_din_a),
      .count(count_a), .done(done_a), .err(err_a));

   instr_encoder #(.ADDR_W(AW_B), .BASE_ADDR(BASE_B), .DEPTH(DEPTH_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_din(imem_din_b),
      .count(count_b), .done(done_b), .err(err_b));

   int passed = 0, total = 0, fails = 0;

   // Reference model of dut_a: mode 0 idle / 1 run / 2 done; m_acc = legal words accepted since start.
   int          m_mode, m_ptr, m_acc, m_addr;
   bit          m_we, m_err;
   logic [31:0] m_din;
   int          b_writes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_legal();
      int s;
      s = $signed(in_imm);
      if (in_fmt > 3'd5) return 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      case (in_fmt)
         3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
         3'd3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
         3'd4:       return (in_imm % 4096) == 0;
         3'd5:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
         default:    return 1'b1;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   // Field placement by shift-and-add, straight from the RV32I format tables.
   function automatic logic [31:0] model_enc();
      int unsigned im, w;
      im = in_imm;
      w  = in_opcode;
      case (in_fmt)
         3'd0: w += (in_rd << 7) + (in_funct3 << 12) + (in_rs1 << 15) + (in_rs2 << 20) + (in_funct7 << 25);
         3'd1: w += (in_rd << 7) + (in_funct3 << 12) + (in_rs1 << 15) + ((im % 4096) << 20);
         3'd2: w += ((im % 32) << 7) + (in_funct3 << 12) + (in_rs1 << 15) + (in_rs2 << 20)
                    + (((im / 32) % 128) << 25);
         3'd3: w += (((im / 2048) % 2) << 7) + (((im / 2) % 16) << 8) + (in_funct3 << 12)
                    + (in_rs1 << 15) + (in_rs2 << 20) + (((im / 32) % 64) << 25)
                    + (((im / 4096) % 2) << 31);
         3'd4: w += (in_rd << 7) + ((im / 4096) << 12);
         3'd5: w += (in_rd << 7) + (((im / 4096) % 256) << 12) + (((im / 2048) % 2) << 20)
                    + (((im / 2) % 1024) << 21) + (((im / 1048576) % 2) << 31);
         default: w = 0;
      endcase
      return w;
   endfunction

   // One clock: check in_ready before the edge, advance the model, check registered outputs after.
   task automatic tick();
      bit exp_rdy, acc, lg;
      logic [31:0] w;
      #2;
      exp_rdy = (m_mode == 1) && !start && (m_acc < DEPTH_A);
      chk("in_ready", {31'd0, in_ready_a}, {31'd0, exp_rdy});
      acc = in_valid && exp_rdy;
      lg  = model_legal();
      w   = model_enc();
      @(posedge clk);
      if (!rst_n) begin
         m_mode = 0; m_ptr = BASE_A; m_acc = 0; m_we = 0; m_err = 0; m_addr = BASE_A; m_din = 0;
      end else if (start) begin
         m_mode = 1; m_ptr = BASE_A; m_acc = 0; m_we = 0; m_err = 0;
      end else begin
         m_we = 0;
         if (acc) begin
            if (lg) begin
               m_we = 1; m_addr = m_ptr; m_din = w;
               m_ptr = (m_ptr + 1) % (1 << AW_A);
               m_acc++;
               if (in_last || m_acc == DEPTH_A) m_mode = 2;
            end else begin
               m_err = 1;
               if (in_last) m_mode = 2;
            end
         end
      end
      #1;
      chk("imem_we",   {31'd0, imem_we_a}, {31'd0, m_we});
      chk("imem_addr", 32'(imem_addr_a), 32'(m_addr));
      chk("imem_din",  imem_din_a, m_din);
      chk("count",     32'(count_a), 32'(m_acc - int'(m_we)));
      chk("done",      {31'd0, done_a}, {31'd0, (m_mode == 2)});
      chk("err",       {31'd0, err_a}, {31'd0, m_err});
      if (imem_we_b) b_writes++;
   endtask

   task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic last);
      in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
      in_funct3 = f3; in_funct7 = f7; in_imm = im; in_last = last;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_fmt = '0; in_opcode = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      m_mode = 0; m_ptr = BASE_A; m_acc = 0; m_we = 0; m_err = 0; m_addr = BASE_A; m_din = 0;
      b_writes = 0;

      // Reset state
      tick(); tick();
      chk("rst_addr", 32'(imem_addr_a), BASE_A);
      rst_n = 1'b1;
      tick();

      // addi x1,x2,5 ; add x3,x1,x2 ; lui x5,0x12345 ; beq x1,x2,-8 (last, wraps address)
      start = 1'b1; tick(); start = 1'b0;
      req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0); tick();
      chk("addi_din", imem_din_a, 32'h00510093);
      chk("addi_addr", 32'(imem_addr_a), BASE_A);
      req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0); tick();
      chk("add_din", imem_din_a, 32'h002081B3);
      chk("add_count", 32'(count_a), 32'd1);
      req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0); tick();
      chk("lui_din", imem_din_a, 32'h123452B7);
      chk("lui_addr", 32'(imem_addr_a), 32'd15);
      req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 1'b1); tick();
      chk("beq_din", imem_din_a, 32'hFE208CE3);
      chk("beq_addr_wrap", 32'(imem_addr_a), 32'd0);
      chk("beq_done", {31'd0, done_a}, 32'd1);
      tick();
      chk("done_ready", {31'd0, in_ready_a}, 32'd0);
      chk("done_count", 32'(count_a), 32'd4);
      in_valid = 1'b0; tick();

      // Illegal format mid-stream, then the 0x800 immediate
      start = 1'b1; tick(); start = 1'b0;
      req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0); tick();
      req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0); tick();
      chk("ill_we", {31'd0, imem_we_a}, 32'd0);
      chk("ill_err", {31'd0, err_a}, 32'd1);
      chk("ill_count", 32'(count_a), 32'd1);
      req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0); tick();
`ifndef INSTR_ENCODER_RANGE_CHECK_EN
      chk("imm800_field", 32'(imem_din_a[31:20]), 32'h800);
`else
      chk("imm800_drop", {31'd0, imem_we_a}, 32'd0);
`endif
      in_valid = 1'b0; tick();

      // DEPTH=4 instance: six back-to-back requests give exactly four writes
      start = 1'b1; tick(); start = 1'b0;
      b_writes = 0;
      for (int i = 0; i < 6; i++) begin
         req(3'd0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
         tick();
      end
      in_valid = 1'b0; tick(); tick();
      chk("b_writes", 32'(b_writes), 32'd4);
      chk("b_done", {31'd0, done_b}, 32'd1);
      chk("b_count", 32'(count_b), 32'd4);
      chk("b_ready", {31'd0, in_ready_b}, 32'd0);

      // Reset in the cycle after an accept aborts the write
      start = 1'b1; tick(); start = 1'b0;
      req(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'd12, 1'b0); tick();
      rst_n = 1'b0; tick();
      rst_n = 1'b1; in_valid = 1'b0; tick();
      chk("rst_no_we", {31'd0, imem_we_a}, 32'd0);

      // start in DONE restarts at BASE_ADDR
      start = 1'b1; tick(); start = 1'b0;
      req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1); tick();
      in_valid = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      req(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0); tick();
      chk("restart_addr", 32'(imem_addr_a), BASE_A);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom_range(99) != 0);
         start    = ($urandom_range(39) == 0) || (m_mode != 1 && $urandom_range(3) == 0);
         in_valid = ($urandom_range(3) != 0);
         in_fmt   = ($urandom_range(9) == 0) ? 3'(6 + $urandom_range(1)) : 3'($urandom_range(5));
         in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
         in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
         in_imm   = $urandom_range(1) ? $urandom : 32'($urandom_range(8191)) - 32'd4096;
         in_last  = ($urandom_range(19) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
